// File: rtl/dec_pkg.sv
// Shared widths, parity-check columns and FSM states for the
// arbitrated SEC decoder.
package dec_pkg;

  localparam int CW_W = 11;
  localparam int D_W  = 7;
  localparam int S_W  = 4;

  // Entry i is the syndrome produced by a flip of codeword bit i.
  localparam logic [CW_W-1:0][S_W-1:0] H_COL = {
    4'b1011, 4'b1010, 4'b1001, 4'b0111,
    4'b0110, 4'b0101, 4'b0011,
    4'b1000, 4'b0100, 4'b0010, 4'b0001
  };

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    OUTPUT
  } state_t;

endpackage

// File: rtl/syndrome_correct.sv
// Combinational syndrome computation and single-bit correction
// of one 11-bit codeword.
module syndrome_correct
  import dec_pkg::*;
(
  input  logic [CW_W-1:0] cx,
  output logic [CW_W-1:0] cx_fix,
  output logic            corr,
  output logic            uncorr
);

  logic [S_W-1:0]  syn;
  logic [CW_W-1:0] flip;

  always_comb begin
    syn = '0;
    for (int i = 0; i < CW_W; i++)
      if (cx[i]) syn = syn ^ H_COL[i];
  end

  // Columns are distinct and nonzero, so flip is at most one-hot.
  always_comb begin
    flip = '0;
    for (int i = 0; i < CW_W; i++)
      flip[i] = (syn == H_COL[i]);
  end

  assign cx_fix = cx ^ flip;
  assign corr   = |flip;
  assign uncorr = (syn != '0) && !corr;

endmodule

// File: rtl/decoder_arb_ctrl.sv
// Two-requester round-robin front end for the SEC decoder.
// Optional error counters are built when DEC_ERRCNT_EN is defined.
module decoder_arb_ctrl
  import dec_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0_valid,
  input  logic [CW_W-1:0] req0_cx,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [CW_W-1:0] req1_cx,
  output logic            req1_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [D_W-1:0]  out_d,
  output logic            out_src,
  output logic            out_corr,
  output logic            out_uncorr,
  output logic            busy
`ifdef DEC_ERRCNT_EN
  ,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt
`endif
);

  state_t          state;
  logic            last_q;
  logic            src_q;
  logic [CW_W-1:0] cx_q;
  logic            any_v;
  logic            gnt;
  logic            take;
  logic [CW_W-1:0] cx_fix;
  logic            fix_corr;
  logic            fix_uncorr;

  assign any_v = req0_valid | req1_valid;

  // On a tie the requester not granted last wins.
  always_comb begin
    gnt = req1_valid;
    if (req0_valid && req1_valid)
      gnt = ~last_q;
  end

  assign take       = !reset && (state == IDLE) && any_v;
  assign req0_ready = take && !gnt;
  assign req1_ready = take && gnt;
  assign busy       = (state != IDLE);

  syndrome_correct u_sc (
    .cx     (cx_q),
    .cx_fix (cx_fix),
    .corr   (fix_corr),
    .uncorr (fix_uncorr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_q     <= 1'b1;
      src_q      <= 1'b0;
      cx_q       <= '0;
      out_valid  <= 1'b0;
      out_d      <= '0;
      out_src    <= 1'b0;
      out_corr   <= 1'b0;
      out_uncorr <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_v) begin
            cx_q   <= gnt ? req1_cx : req0_cx;
            src_q  <= gnt;
            last_q <= gnt;
            state  <= DECODE;
          end
        end
        DECODE: begin
          out_d      <= cx_fix[CW_W-1:S_W];
          out_src    <= src_q;
          out_corr   <= fix_corr;
          out_uncorr <= fix_uncorr;
          out_valid  <= 1'b1;
          state      <= OUTPUT;
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DEC_ERRCNT_EN
  logic hs;

  assign hs = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset || cnt_clr) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (hs) begin
      if (out_corr && !(&corr_cnt))
        corr_cnt <= corr_cnt + 1'b1;
      if (out_uncorr && !(&uncorr_cnt))
        uncorr_cnt <= uncorr_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_decoder_arb_ctrl.sv
// Self-checking bench for decoder_arb_ctrl: directed cases plus
// random traffic against a brute-force Hamming reference model.
module tb_decoder_arb_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [10:0] req0_cx, req1_cx;
  logic        req0_ready, req1_ready;
  logic        out_valid, out_ready;
  logic [6:0]  out_d;
  logic        out_src, out_corr, out_uncorr, busy;
`ifdef DEC_ERRCNT_EN
  logic        cnt_clr;
  logic [15:0] corr_cnt, uncorr_cnt;
`endif

  int passed = 0;
  int total  = 0;
  int rr_last = 1;
  int m_corr = 0;
  int m_unc  = 0;
  int hcol [11] = '{1, 2, 4, 8, 3, 5, 6, 7, 9, 10, 11};

  decoder_arb_ctrl #(.CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_cx    (req0_cx),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_cx    (req1_cx),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_d      (out_d),
    .out_src    (out_src),
    .out_corr   (out_corr),
    .out_uncorr (out_uncorr),
    .busy       (busy)
`ifdef DEC_ERRCNT_EN
    ,
    .cnt_clr    (cnt_clr),
    .corr_cnt   (corr_cnt),
    .uncorr_cnt (uncorr_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
  endtask

  function automatic int syn(input logic [10:0] c);
    int s = 0;
    for (int i = 0; i < 11; i++)
      if (c[i]) s = s ^ hcol[i];
    return s;
  endfunction

  // Search for the single flip that yields a valid codeword.
  task automatic ref_dec(input logic [10:0] c, output logic [6:0] d,
                         output bit co, output bit un);
    logic [10:0] t;
    logic [10:0] m;
    t = c;
    co = 0;
    un = 0;
    if (syn(c) != 0) begin
      un = 1;
      for (int i = 0; i < 11; i++) begin
        m = 11'd1 << i;
        if (syn(c ^ m) == 0) begin
          t = c ^ m;
          co = 1;
          un = 0;
        end
      end
    end
    d = t[10:4];
  endtask

  function automatic logic [10:0] gen_cx();
    logic [10:0] c;
    int mode;
    c = 11'($urandom);
    mode = $urandom_range(2, 0);
    if (mode != 2) begin
      c[3:0] = 4'd0;
      c[3:0] = 4'(syn(c));
      if (mode == 1) c[$urandom_range(10, 0)] ^= 1'b1;
    end
    return c;
  endfunction

  task automatic xact(input int stall, input bit drop, input bit glitch);
    int n, g;
    logic [10:0] c;
    logic [6:0] d;
    bit co, un;
    #1;
    n = 0;
    while (!(req0_ready || req1_ready) && n < 8) begin
      tick();
      n++;
    end
    chk("grant_seen", 32'(req0_ready | req1_ready), 1);
    if (!(req0_ready || req1_ready)) return;
    chk("one_ready", 32'(req0_ready & req1_ready), 0);
    if (req0_valid && req1_valid) g = 1 - rr_last;
    else g = req1_valid ? 1 : 0;
    chk("grant_idx", 32'(req1_ready), 32'(g));
    rr_last = g;
    c = g ? req1_cx : req0_cx;
    ref_dec(c, d, co, un);
    tick();
    if (g == 1) req1_cx = gen_cx();
    else req0_cx = gen_cx();
    if (drop) begin
      if (g == 1) req1_valid = 0;
      else req0_valid = 0;
    end
    if (glitch) begin
      if (g == 1) req0_valid = 1;
      else req1_valid = 1;
    end
    #1;
    chk("dec_noready", 32'(req0_ready | req1_ready), 0);
    chk("dec_nvalid", 32'(out_valid), 0);
    chk("dec_busy", 32'(busy), 1);
    tick();
    if (glitch) begin
      req0_valid = 0;
      req1_valid = 0;
    end
    chk("out_valid", 32'(out_valid), 1);
    chk("out_d", 32'(out_d), 32'(d));
    chk("out_src", 32'(out_src), 32'(g));
    chk("out_corr", 32'(out_corr), 32'(co));
    chk("out_uncorr", 32'(out_uncorr), 32'(un));
    for (int k = 0; k < stall; k++) begin
      tick();
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_d", 32'(out_d), 32'(d));
      chk("stall_flags", 32'({out_src, out_corr, out_uncorr}),
          32'({g[0], co, un}));
      chk("stall_noready", 32'(req0_ready | req1_ready), 0);
    end
    out_ready = 1;
    tick();
    out_ready = 0;
    if (co) m_corr++;
    if (un) m_unc++;
    chk("post_valid", 32'(out_valid), 0);
    chk("post_busy", 32'(busy), 0);
  endtask

  initial begin
    reset = 1;
    req0_valid = 1;
    req1_valid = 0;
    req0_cx = '0;
    req1_cx = '0;
    out_ready = 1;
`ifdef DEC_ERRCNT_EN
    cnt_clr = 0;
`endif
    tick();
    chk("rst_ready", 32'(req0_ready | req1_ready), 0);
    tick();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out", 32'({out_d, out_src, out_corr, out_uncorr}), 0);
    req0_valid = 0;
    out_ready = 0;
    reset = 0;
    tick();
    chk("idle_busy", 32'(busy), 0);
    chk("idle_nready", 32'(req0_ready | req1_ready), 0);
    // out_ready with nothing pending changes nothing.
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("stray_ready", 32'(out_valid | busy), 0);

    req0_valid = 1;
    req0_cx = 11'd0;
    xact(0, 1, 0);

    req1_valid = 1;
    req1_cx = 11'b000_0100_0000;
    xact(0, 1, 0);

    req0_valid = 1;
    req0_cx = 11'b000_0000_1100;
    xact(0, 1, 0);

    // Last grant was 0; both tie so 1 then 0, 1, 0.
    req0_valid = 1;
    req1_valid = 1;
    req0_cx = gen_cx();
    req1_cx = gen_cx();
    for (int k = 0; k < 4; k++) xact(0, 0, 0);
    req0_valid = 0;
    req1_valid = 0;

    // Long stall, plus a requester that gives up before service.
    req1_valid = 1;
    req1_cx = gen_cx();
    xact(5, 1, 1);
    req0_valid = 1;
    req1_valid = 1;
    xact(0, 1, 0);
    req0_valid = 0;
    req1_valid = 0;

    // Reset while in DECODE abandons the transaction.
    req0_valid = 1;
    req0_cx = 11'h7ff;
    #1;
    tick();
    req0_valid = 0;
    reset = 1;
    tick();
    reset = 0;
    rr_last = 1;
    m_corr = 0;
    m_unc = 0;
    chk("abort_valid", 32'(out_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    tick();
    chk("abort_idle", 32'(out_valid | busy), 0);

    for (int k = 0; k < 40; k++) begin
      req0_valid = 1'($urandom);
      req1_valid = 1'($urandom);
      if (!req0_valid && !req1_valid) req1_valid = 1;
      req0_cx = gen_cx();
      req1_cx = gen_cx();
      xact($urandom_range(3, 0), 1, 0);
      req0_valid = 0;
      req1_valid = 0;
    end

`ifdef DEC_ERRCNT_EN
    chk("cnt_corr_rand", 32'(corr_cnt), 32'(m_corr));
    chk("cnt_unc_rand", 32'(uncorr_cnt), 32'(m_unc));
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    m_corr = 0;
    m_unc = 0;
    for (int k = 0; k < 3; k++) begin
      req0_valid = 1;
      req0_cx = 11'd1 << (4 + k);
      xact(0, 1, 0);
    end
    req1_valid = 1;
    req1_cx = 11'b000_0000_1100;
    xact(0, 1, 0);
    chk("cnt_corr3", 32'(corr_cnt), 3);
    chk("cnt_unc1", 32'(uncorr_cnt), 1);
    cnt_clr = 1;
    req0_valid = 1;
    req0_cx = 11'b000_0000_1100;
    xact(0, 1, 0);
    cnt_clr = 0;
    chk("cnt_clr_corr", 32'(corr_cnt), 0);
    chk("cnt_clr_unc", 32'(uncorr_cnt), 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/decoder_arb_ctrl.md
DECODER_ARB_CTRL -- requirements
Module: decoder_arb_ctrl

Interface
REQ-001 Parameter: CNT_W, 16, width of the error statistics counters.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 offers a codeword.
REQ-005 req0_cx  input  11  requester 0 codeword; bits 3:0 parity, bits 10:4 data.
REQ-006 req0_ready  output  1  requester 0 codeword accepted this cycle.
REQ-007 req1_valid, req1_cx, req1_ready  as REQ-004 to REQ-006, for requester 1.
REQ-008 out_valid  output  1  decoded result available.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 out_d  output  7  corrected data, equal to corrected cx bits 10:4.
REQ-011 out_src  output  1  requester index of the result.
REQ-012 out_corr  output  1  single-bit error corrected.
REQ-013 out_uncorr  output  1  nonzero syndrome matching no column; data passed uncorrected.
REQ-014 busy  output  1  state is not IDLE.
REQ-015 cnt_clr  input  1  clear both counters (present only with DEC_ERRCNT_EN).
REQ-016 corr_cnt, uncorr_cnt  output  CNT_W each  error counts (present only with DEC_ERRCNT_EN).

Function
REQ-017 FSM states: IDLE, DECODE, OUTPUT.
REQ-018 IDLE: if any reqN_valid is high, grant one requester, assert its ready combinationally in that cycle, capture its cx, and go to DECODE.
REQ-019 Arbitration: round-robin. On simultaneous valids, grant the requester not granted last. After reset, requester 0 wins the first tie.
REQ-020 At most one ready is high in any cycle. No ready is high outside IDLE.
REQ-021 DECODE, one cycle: syndrome s[k] = XOR of captured cx bits whose H column has bit k set. Register the result, then go to OUTPUT.
REQ-022 H columns, as s[3:0]:
  - bits 0-3: 0001, 0010, 0100, 1000
  - bits 4-10: 0011, 0101, 0110, 0111, 1001, 1010, 1011
REQ-023 Syndrome handling:
  - s = 0: no change, out_corr = 0, out_uncorr = 0.
  - s equals column i: invert bit i, out_corr = 1.
  - s in {1100, 1101, 1110, 1111}: no change, out_uncorr = 1.
REQ-024 OUTPUT: assert out_valid with stable out_d, out_src, out_corr and out_uncorr until out_ready is high; on that handshake go to IDLE.
REQ-025 Latency: out_valid rises 2 cycles after the accepting edge. Minimum spacing between acceptances is 3 cycles.
REQ-026 A requester that drops valid before it is granted is not served, and the round-robin pointer does not change.
REQ-027 out_ready while out_valid is low has no effect.

Reset
REQ-028 reset (synchronous) forces:
  - state IDLE, round-robin pointer to requester 1 last-granted
  - out_valid, out_d, out_src, out_corr, out_uncorr and busy to 0
  - counters to 0
REQ-029 reset in any state abandons the transaction in flight without producing a result. reset has priority over all other inputs.

Configuration
REQ-030 With DEC_ERRCNT_EN defined:
  - corr_cnt and uncorr_cnt increment on each out_valid & out_ready handshake whose out_corr or out_uncorr respectively is 1.
  - Both counters saturate at all-ones.
  - cnt_clr zeroes both counters and has priority over an increment in the same cycle.
REQ-031 Without DEC_ERRCNT_EN: cnt_clr, corr_cnt, uncorr_cnt and the counter logic are absent. All other behaviour is identical.

Structure
REQ-032 Shared package dec_pkg holds:
  - widths CW_W = 11, D_W = 7, S_W = 4
  - the 11 H column constants
  - the FSM state enum
REQ-033 Syndrome computation and correction sit in one combinational sub-module, syndrome_correct: inputs cx; outputs corrected cx, corr, uncorr. The FSM and arbiter stay in decoder_arb_ctrl.

Verification
REQ-034 req0_cx = 0 alone -> req0_ready in the same cycle; 2 cycles later out_valid, out_d = 0, out_src = 0, out_corr = 0, out_uncorr = 0.
REQ-035 req1_cx = 11'b000_0100_0000 (bit 6 flipped from 0) -> s = 0110, out_d = 0, out_corr = 1, out_src = 1.
REQ-036 cx = 11'b000_0000_1100 (s = 1100) -> out_uncorr = 1, out_d = 0, out_corr = 0.
REQ-037 Both valids held high continuously for 4 transactions -> grants alternate 0, 1, 0, 1; ready is never high for both at once.
REQ-038 out_ready held low for 5 cycles in OUTPUT -> outputs stay stable, no new ready; reset asserted in DECODE -> next cycle state IDLE, out_valid = 0.
REQ-039 With DEC_ERRCNT_EN: 3 corrected results and 1 uncorrectable result -> corr_cnt = 3, uncorr_cnt = 1; cnt_clr asserted together with an increment -> both counters 0.
